// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation station: entry layout, issue bundle,
// CDB wakeup and bundle formation.
package rs_pkg;

    localparam int OP_W      = 10;
    // Tag fields are stored at a fixed maximum width; instances use TAG_W <= TAG_MAX_W.
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic                 is_branch;
        logic [31:0]          pc;
        logic [31:0]          imm;
        logic                 use_pc;
        logic                 use_imm;
        logic [31:0]          rs1;
        logic [31:0]          rs2;
        logic                 rs1_pend;
        logic                 rs2_pend;
        logic [TAG_MAX_W-1:0] rs1_tag;
        logic [TAG_MAX_W-1:0] rs2_tag;
        logic [TAG_MAX_W-1:0] dst_tag;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic                 is_branch;
        logic [31:0]          pc_plus4;
        logic [31:0]          rd1;
        logic [31:0]          rd2;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic [TAG_MAX_W-1:0] dst_tag;
    } issue_bundle_t;

    function automatic rs_entry_t rs_wake(
        input rs_entry_t            e,
        input logic                 hit_valid,
        input logic [TAG_MAX_W-1:0] tag,
        input logic [31:0]          data
    );
        rs_entry_t w;
        w = e;
        if (hit_valid && e.rs1_pend && (e.rs1_tag == tag)) begin
            w.rs1      = data;
            w.rs1_pend = 1'b0;
        end
        if (hit_valid && e.rs2_pend && (e.rs2_tag == tag)) begin
            w.rs2      = data;
            w.rs2_pend = 1'b0;
        end
        return w;
    endfunction

    function automatic issue_bundle_t rs_bundle(input rs_entry_t e);
        issue_bundle_t b;
        b.op        = e.op;
        b.is_branch = e.is_branch;
        b.pc_plus4  = e.pc + 32'd4;
        b.rd1       = e.rs1;
        b.rd2       = e.rs2;
        b.vj        = e.use_pc  ? e.pc  : e.rs1;
        b.vk        = e.use_imm ? e.imm : e.rs2;
        b.dst_tag   = e.dst_tag;
        return b;
    endfunction

endpackage

// File: rtl/rs_select.sv
// Oldest-first pick: returns the lowest-index set bit of the ready vector.
module rs_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_issue.sv
// Reservation station: collapsing queue of tagged ops with CDB wakeup, oldest-ready
// select into a registered issue bundle, and whole-station flush.
module rs_issue
    import rs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [OP_W-1:0]   enq_op,
    input  logic              enq_is_branch,
    input  logic [31:0]       enq_pc,
    input  logic [31:0]       enq_imm,
    input  logic              enq_use_pc,
    input  logic              enq_use_imm,
    input  logic [31:0]       enq_rs1,
    input  logic [31:0]       enq_rs2,
    input  logic              enq_rs1_pend,
    input  logic              enq_rs2_pend,
    input  logic [TAG_W-1:0]  enq_rs1_tag,
    input  logic [TAG_W-1:0]  enq_rs2_tag,
    input  logic [TAG_W-1:0]  enq_dst_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [31:0]       cdb_data,
    input  logic              flush,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [OP_W-1:0]   issue_op,
    output logic              issue_is_branch_op,
    output logic [31:0]       issue_pc_plus4,
    output logic [31:0]       issue_rd1,
    output logic [31:0]       issue_rd2,
    output logic [31:0]       issue_vj,
    output logic [31:0]       issue_vk,
    output logic [TAG_W-1:0]  issue_dst_tag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t [DEPTH-1:0]  entries_q;
    rs_entry_t [DEPTH-1:0]  entries_d;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [CNT_W-1:0]       count_kept;
    issue_bundle_t          issue_q;
    logic                   issue_valid_q;

    logic [DEPTH-1:0]       ready_vec;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic                   take;
    logic                   enq_fire;
    rs_entry_t              enq_entry;
    issue_bundle_t          sel_bundle;
    logic [TAG_MAX_W-1:0]   cdb_tag_x;
    logic                   unused_tag_bits;

    assign cdb_tag_x = TAG_MAX_W'(cdb_tag);
    assign enq_ready = (count_q < CNT_W'(DEPTH));
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign take      = sel_found && (!issue_valid_q || issue_ready) && !flush;

    // Readiness uses registered pend bits only, so a wakeup is selectable next cycle.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (CNT_W'(i) < count_q) && !entries_q[i].rs1_pend
                           && !entries_q[i].rs2_pend;
        end
    end

    rs_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .ready_i (ready_vec),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    assign sel_bundle = rs_bundle(entries_q[sel_idx]);

    always_comb begin
        rs_entry_t raw;
        raw           = '0;
        raw.op        = enq_op;
        raw.is_branch = enq_is_branch;
        raw.pc        = enq_pc;
        raw.imm       = enq_imm;
        raw.use_pc    = enq_use_pc;
        raw.use_imm   = enq_use_imm;
        raw.rs1       = enq_rs1;
        raw.rs2       = enq_rs2;
        raw.rs1_pend  = enq_rs1_pend;
        raw.rs2_pend  = enq_rs2_pend;
        raw.rs1_tag   = TAG_MAX_W'(enq_rs1_tag);
        raw.rs2_tag   = TAG_MAX_W'(enq_rs2_tag);
        raw.dst_tag   = TAG_MAX_W'(enq_dst_tag);
        enq_entry     = rs_wake(raw, cdb_valid, cdb_tag_x, cdb_data);
    end

    // Collapse above the issued slot, wake everything, then drop the new op on top.
    always_comb begin
        entries_d  = entries_q;
        count_kept = count_q - CNT_W'(take);
        for (int i = 0; i < DEPTH; i++) begin
            if (take && (i >= int'(sel_idx))) begin
                entries_d[i] = rs_wake(entries_q[(i < DEPTH - 1) ? i + 1 : i],
                                       cdb_valid, cdb_tag_x, cdb_data);
            end else begin
                entries_d[i] = rs_wake(entries_q[i], cdb_valid, cdb_tag_x, cdb_data);
            end
            if (enq_fire && (CNT_W'(i) == count_kept)) begin
                entries_d[i] = enq_entry;
            end
        end
        count_d = flush ? '0 : (count_kept + CNT_W'(enq_fire));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q     <= '0;
            count_q       <= '0;
            issue_q       <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            if (flush) begin
                issue_valid_q <= 1'b0;
            end else if (take) begin
                issue_valid_q <= 1'b1;
                issue_q       <= sel_bundle;
            end else if (issue_ready) begin
                issue_valid_q <= 1'b0;
            end
        end
    end

    assign issue_valid        = issue_valid_q;
    assign issue_op           = issue_q.op;
    assign issue_is_branch_op = issue_q.is_branch;
    assign issue_pc_plus4     = issue_q.pc_plus4;
    assign issue_rd1          = issue_q.rd1;
    assign issue_rd2          = issue_q.rd2;
    assign issue_vj           = issue_q.vj;
    assign issue_vk           = issue_q.vk;
    assign issue_dst_tag      = issue_q.dst_tag[TAG_W-1:0];
    assign unused_tag_bits    = ^issue_q.dst_tag;

endmodule

// File: tb/tb_rs_issue.sv
// Directed bench for rs_issue: stimulus pushes expected bundles, a negedge monitor
// pops and compares them on every issue handshake.
module tb_rs_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic        enq_ready;
    logic [9:0]  enq_op;
    logic        enq_is_branch;
    logic [31:0] enq_pc;
    logic [31:0] enq_imm;
    logic        enq_use_pc;
    logic        enq_use_imm;
    logic [31:0] enq_rs1;
    logic [31:0] enq_rs2;
    logic        enq_rs1_pend;
    logic        enq_rs2_pend;
    logic [3:0]  enq_rs1_tag;
    logic [3:0]  enq_rs2_tag;
    logic [3:0]  enq_dst_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [9:0]  issue_op;
    logic        issue_is_branch_op;
    logic [31:0] issue_pc_plus4;
    logic [31:0] issue_rd1;
    logic [31:0] issue_rd2;
    logic [31:0] issue_vj;
    logic [31:0] issue_vk;
    logic [3:0]  issue_dst_tag;

    always #5 clk = ~clk;

    rs_issue #(.DEPTH(4), .TAG_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .enq_valid          (enq_valid),
        .enq_ready          (enq_ready),
        .enq_op             (enq_op),
        .enq_is_branch      (enq_is_branch),
        .enq_pc             (enq_pc),
        .enq_imm            (enq_imm),
        .enq_use_pc         (enq_use_pc),
        .enq_use_imm        (enq_use_imm),
        .enq_rs1            (enq_rs1),
        .enq_rs2            (enq_rs2),
        .enq_rs1_pend       (enq_rs1_pend),
        .enq_rs2_pend       (enq_rs2_pend),
        .enq_rs1_tag        (enq_rs1_tag),
        .enq_rs2_tag        (enq_rs2_tag),
        .enq_dst_tag        (enq_dst_tag),
        .cdb_valid          (cdb_valid),
        .cdb_tag            (cdb_tag),
        .cdb_data           (cdb_data),
        .flush              (flush),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_op           (issue_op),
        .issue_is_branch_op (issue_is_branch_op),
        .issue_pc_plus4     (issue_pc_plus4),
        .issue_rd1          (issue_rd1),
        .issue_rd2          (issue_rd2),
        .issue_vj           (issue_vj),
        .issue_vk           (issue_vk),
        .issue_dst_tag      (issue_dst_tag)
    );

    typedef struct packed {
        logic [9:0]  op;
        logic        br;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  dst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, req);
        end
    endfunction

    function automatic void expect_b(input logic [9:0] op, input logic br, input logic [31:0] pc4,
                                     input logic [31:0] rd1, input logic [31:0] rd2,
                                     input logic [31:0] vj, input logic [31:0] vk,
                                     input logic [3:0] dst);
        exp_t e;
        e.op  = op;
        e.br  = br;
        e.pc4 = pc4;
        e.rd1 = rd1;
        e.rd2 = rd2;
        e.vj  = vj;
        e.vk  = vk;
        e.dst = dst;
        exp_q.push_back(e);
    endfunction

    // Monitor: a handshake completes on the next posedge whenever valid & ready here.
    always @(negedge clk) begin : monitor
        exp_t act;
        exp_t e;
        if (!reset && issue_valid && issue_ready) begin
            act = {issue_op, issue_is_branch_op, issue_pc_plus4, issue_rd1, issue_rd2,
                   issue_vj, issue_vk, issue_dst_tag};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got op 0x%03h, want no issue", issue_op);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL bundle: got %h, want %h", act, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [9:0] op, input logic br, input logic [31:0] pc,
                             input logic [31:0] imm, input logic upc, input logic uimm,
                             input logic [31:0] r1, input logic p1, input logic [3:0] t1,
                             input logic [31:0] r2, input logic p2, input logic [3:0] t2,
                             input logic [3:0] dst);
        enq_valid     = 1'b1;
        enq_op        = op;
        enq_is_branch = br;
        enq_pc        = pc;
        enq_imm       = imm;
        enq_use_pc    = upc;
        enq_use_imm   = uimm;
        enq_rs1       = r1;
        enq_rs1_pend  = p1;
        enq_rs1_tag   = t1;
        enq_rs2       = r2;
        enq_rs2_pend  = p2;
        enq_rs2_tag   = t2;
        enq_dst_tag   = dst;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        enq_valid = 1'b0; enq_op = '0; enq_is_branch = 1'b0; enq_pc = '0; enq_imm = '0;
        enq_use_pc = 1'b0; enq_use_imm = 1'b0; enq_rs1 = '0; enq_rs2 = '0;
        enq_rs1_pend = 1'b0; enq_rs2_pend = 1'b0; enq_rs1_tag = '0; enq_rs2_tag = '0;
        enq_dst_tag = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
        issue_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        chk1("reset_issue_valid", issue_valid, 1'b0);
        chk1("reset_enq_ready", enq_ready, 1'b1);
        chk("reset_vj", issue_vj, 32'h0);
        chk("reset_pc_plus4", issue_pc_plus4, 32'h0);

        // Simple add, no pending sources
        expect_b(10'h001, 1'b0, 32'h104, 32'd5, 32'd7, 32'd5, 32'd7, 4'h1);
        drive_enq(10'h001, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'd5, 1'b0, 4'h0, 32'd7, 1'b0, 4'h0, 4'h1);
        tick();
        enq_valid = 1'b0;
        chk1("t1_not_before_select", issue_valid, 1'b0);
        tick();
        chk1("t1_issue_valid", issue_valid, 1'b1);
        chk("t1_pc_plus4", issue_pc_plus4, 32'h104);
        tick();
        chk1("t1_drained", issue_valid, 1'b0);

        // rs1 pending on tag 3, woken later
        expect_b(10'h002, 1'b0, 32'h204, 32'hDEAD, 32'h11, 32'hDEAD, 32'h11, 4'h2);
        drive_enq(10'h002, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'hBAD, 1'b1, 4'h3, 32'h11, 1'b0, 4'h0, 4'h2);
        tick();
        enq_valid = 1'b0;
        tick();
        tick();
        chk1("t2_blocked", issue_valid, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 4'h3; cdb_data = 32'hDEAD;
        tick();
        cdb_valid = 1'b0;
        chk1("t2_wake_not_yet", issue_valid, 1'b0);
        tick();
        chk1("t2_issue_after_wake", issue_valid, 1'b1);
        chk("t2_vj", issue_vj, 32'hDEAD);
        tick();

        // Broadcast in the enqueue cycle itself
        expect_b(10'h003, 1'b0, 32'h304, 32'hDEAD, 32'h22, 32'hDEAD, 32'h22, 4'h3);
        drive_enq(10'h003, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 4'h3, 32'h22, 1'b0, 4'h0, 4'h3);
        cdb_valid = 1'b1; cdb_tag = 4'h3; cdb_data = 32'hDEAD;
        tick();
        enq_valid = 1'b0;
        cdb_valid = 1'b0;
        tick();
        chk1("t2b_issue_valid", issue_valid, 1'b1);
        chk("t2b_vj", issue_vj, 32'hDEAD);
        tick();

        // Fill the station with ops blocked on tag 9
        for (int i = 0; i < 4; i++) begin
            expect_b(10'(16 + i), 1'b0, 32'(32'h404 + 16 * i), 32'h900, 32'(32'h30 + i),
                     32'h900, 32'(32'h30 + i), 4'(4 + i));
            drive_enq(10'(16 + i), 1'b0, 32'(32'h400 + 16 * i), 32'h0, 1'b0, 1'b0, 32'(i + 1),
                      1'b1, 4'h9, 32'(32'h30 + i), 1'b0, 4'h0, 4'(4 + i));
            tick();
        end
        chk1("t3_full_enq_ready", enq_ready, 1'b0);
        drive_enq(10'h3FF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'hF);
        tick();
        enq_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 4'h5; cdb_data = 32'h555;
        tick();
        cdb_valid = 1'b0;
        tick();
        chk1("t3_foreign_tag_no_wake", issue_valid, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 4'h9; cdb_data = 32'h900;
        tick();
        cdb_valid = 1'b0;
        chk1("t3_wake_cycle_valid", issue_valid, 1'b0);
        chk1("t3_wake_cycle_enq_ready", enq_ready, 1'b0);
        tick();
        chk1("t3_first_issue", issue_valid, 1'b1);
        chk1("t3_enq_ready_back", enq_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk1("t3_back_to_back", issue_valid, 1'b1);
        end
        tick();
        chk1("t3_drained", issue_valid, 1'b0);

        // Stall with two ready entries
        issue_ready = 1'b0;
        expect_b(10'h020, 1'b0, 32'h504, 32'hA1, 32'hA2, 32'hA1, 32'hA2, 4'hA);
        expect_b(10'h021, 1'b0, 32'h604, 32'hB1, 32'hB2, 32'hB1, 32'hB2, 4'hB);
        drive_enq(10'h020, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'hA1, 1'b0, 4'h0, 32'hA2, 1'b0, 4'h0, 4'hA);
        tick();
        drive_enq(10'h021, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0, 32'hB1, 1'b0, 4'h0, 32'hB2, 1'b0, 4'h0, 4'hB);
        tick();
        enq_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk1("t4_stall_valid", issue_valid, 1'b1);
            chk("t4_stall_vj", issue_vj, 32'hA1);
            chk("t4_stall_pc_plus4", issue_pc_plus4, 32'h504);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        chk1("t4_second_valid", issue_valid, 1'b1);
        chk("t4_second_vj", issue_vj, 32'hB1);
        tick();
        chk1("t4_drained", issue_valid, 1'b0);

        // use_pc / use_imm with pc+4 wrap
        expect_b(10'h030, 1'b1, 32'h0, 32'h55, 32'h66, 32'hFFFFFFFC, 32'h8, 4'h5);
        drive_enq(10'h030, 1'b1, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b1, 32'h55, 1'b0, 4'h0, 32'h66, 1'b0, 4'h0, 4'h5);
        tick();
        enq_valid = 1'b0;
        tick();
        chk("t5_pc_plus4_wrap", issue_pc_plus4, 32'h0);
        chk("t5_vk_imm", issue_vk, 32'h8);
        tick();

        // Flush with a stalled bundle, 3 queued entries and a simultaneous enqueue
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_enq(10'(64 + i), 1'b0, 32'(32'h700 + 16 * i), 32'h0, 1'b0, 1'b0, 32'(i + 32'hC0),
                      1'b0, 4'h0, 32'h1, 1'b0, 4'h0, 4'(i));
            tick();
        end
        enq_valid = 1'b0;
        chk1("t6_stalled_valid", issue_valid, 1'b1);
        chk("t6_stalled_op", {22'd0, issue_op}, 32'h040);
        flush = 1'b1;
        drive_enq(10'h3FE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'hE);
        cdb_valid = 1'b1; cdb_tag = 4'h0; cdb_data = 32'h1234;
        tick();
        flush = 1'b0;
        enq_valid = 1'b0;
        cdb_valid = 1'b0;
        chk1("t6_flush_valid", issue_valid, 1'b0);
        chk1("t6_flush_enq_ready", enq_ready, 1'b1);
        issue_ready = 1'b1;
        tick();
        tick();
        chk1("t6_station_empty", issue_valid, 1'b0);
        expect_b(10'h050, 1'b0, 32'h804, 32'hD1, 32'hD2, 32'hD1, 32'hD2, 4'hD);
        drive_enq(10'h050, 1'b0, 32'h800, 32'h0, 1'b0, 1'b0, 32'hD1, 1'b0, 4'h0, 32'hD2, 1'b0, 4'h0, 4'hD);
        tick();
        enq_valid = 1'b0;
        tick();
        chk1("t6_post_flush_issue", issue_valid, 1'b1);
        tick();
        chk1("t6_post_flush_drained", issue_valid, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_issue.md
Name: rs_issue

Overview:
- Reservation station feeding the execute stage; it is the initiator on the operand/issue interface that the execute stage responds to.
- Buffers decoded ops with tagged source operands and snoops the common data bus (CDB) to wake pending operands.
- Issues the oldest fully-ready op as a registered bundle (Op, is_branch_op, pc_plus4, rd1, rd2, Vj, Vk) and supports whole-station flush on a taken branch.

Parameters:
DEPTH, 4, number of entries (2..8)
TAG_W, 4, width of producer tags on the CDB

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
enq_valid  input  1  decoder offers an op
enq_ready  output  1  station can accept an op
enq_op  input  10  ALU/mul/div/branch opcode
enq_is_branch  input  1  op is a branch/jump
enq_pc  input  32  op PC
enq_imm  input  32  immediate
enq_use_pc  input  1  Vj = pc instead of rs1
enq_use_imm  input  1  Vk = imm instead of rs2
enq_rs1, enq_rs2  input  32 each  source values, valid when the matching pending bit is 0
enq_rs1_pend, enq_rs2_pend  input  1 each  source still being produced
enq_rs1_tag, enq_rs2_tag  input  TAG_W each  producer tags
enq_dst_tag  input  TAG_W  tag this op will broadcast
cdb_valid  input  1  CDB broadcast this cycle
cdb_tag  input  TAG_W  broadcast tag
cdb_data  input  32  broadcast value
flush  input  1  discard all entries and the issue register
issue_valid  output  1  registered issue bundle valid
issue_ready  input  1  execute stage accepts the bundle
issue_op  output  10  to execute Op
issue_is_branch_op  output  1  to execute is_branch_op
issue_pc_plus4  output  32  pc + 4, modulo 2^32
issue_rd1, issue_rd2  output  32 each  rs1/rs2 values (branch compare operands)
issue_vj, issue_vk  output  32 each  ALU operands per use_pc/use_imm
issue_dst_tag  output  TAG_W  destination tag

Behaviour:
- Reset, synchronous and active-high: all entries invalid, count = 0; issue_valid = 0 and all issue_* data outputs = 0. enq_ready = 1 in the cycle after reset.
- Storage is a collapsing queue: slot 0 is the oldest entry; valid slots are contiguous from slot 0.
- enq_ready = (count < DEPTH). A slot freed by an issue in the same cycle is not counted toward enq_ready.
- Enqueue on enq_valid & enq_ready. The new entry lands at slot count, or at slot count-1 when an older entry issues in the same cycle.
- Enqueue bypass: if a source is pending and cdb_valid & cdb_tag == its tag in the enqueue cycle, store it as ready with cdb_data.
- Wakeup: every valid pending source whose tag matches cdb_tag while cdb_valid is high latches cdb_data and clears its pending bit. Multiple entries may wake on the same broadcast.
- An entry is ready when both pending bits are 0 at the start of the cycle. An entry woken in cycle t is selectable in t+1.
- Select: the lowest-index ready entry, taken only when the issue register is free, i.e. !issue_valid | issue_ready.
- The selected entry is removed and slots above it shift down by one in the same cycle. The bundle appears registered in the next cycle, so latency is ready -> issue_valid of 1 cycle.
- Bundle computation:
  - issue_vj = use_pc ? pc : rs1
  - issue_vk = use_imm ? imm : rs2
  - issue_pc_plus4 = pc + 32'd4
- Stall: while issue_valid & !issue_ready, every issue_* output holds unchanged and no new selection occurs. Wakeup and enqueue continue during a stall.
- Back-to-back: with issue_ready held at 1 and ready entries present, one issue occurs per cycle.
- Flush has priority over everything: next cycle count = 0 and issue_valid = 0; enqueue and CDB activity in the flush cycle are ignored. Flush mid-stall drops the held bundle.
- A CDB tag matching no pending source has no effect.

Decomposition:
- Shared package rs_pkg holds:
  - typedef rs_entry_t: op, is_branch, pc, imm, use_pc, use_imm, rs1/rs2 values, pend bits, tags, dst_tag
  - typedef issue_bundle_t
  - localparam OP_W = 10
- One sub-module, rs_select: priority encoder over the ready vector returning found and index; purely combinational, parameterised by DEPTH.

Test Plan:
- Reset, then enqueue an add with rs1 = 5, rs2 = 7, no pending sources, pc = 0x100 -> next cycle issue_valid = 1, vj = 5, vk = 7, rd1 = 5, rd2 = 7, pc_plus4 = 0x104.
- Enqueue an op with rs1 pending on tag 3, then cdb_valid with tag 3, data 0xDEAD -> issue one cycle after the broadcast with vj = 0xDEAD. A broadcast on tag 3 in the enqueue cycle itself also yields vj = 0xDEAD.
- Fill 4 entries, all blocked on tag 9 -> enq_ready = 0. Broadcast tag 9 -> entries issue one per cycle in slot order 0, 1, 2, 3, and enq_ready returns to 1.
- Hold issue_ready = 0 with 2 ready entries -> the bundle is stable for 5 cycles. Raise issue_ready -> the second entry issues the following cycle.
- enq_use_pc = 1, enq_use_imm = 1, pc = 0xFFFFFFFC, imm = 8 -> vj = 0xFFFFFFFC, vk = 8, pc_plus4 = 0x00000000 (wrap).
- 3 entries valid, one bundle stalled, flush asserted with simultaneous enq_valid -> next cycle issue_valid = 0, count = 0, enq_ready = 1, and the enqueued op is discarded.
